// File: rtl/pc_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared definitions for the instruction fetch stage (pc_fetch_unit and its
// instruction buffer fetch_fifo):
//   NOP_INSTR        - word presented to decode while the buffer is empty
//   DEFAULT_RESET_PC - default fetch address after reset
//   PC_INCR          - sequential fetch stride in bytes
//   fetch_state_e    - fetch FSM encoding (REQ / WAIT / DROP)
//   fetch_entry_t    - one buffered fetch: {pc, instr}
//   align_pc()       - forces a byte address to word alignment
// -----------------------------------------------------------------------------
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_if
// Instruction-memory read channel (req/gnt/rvalid handshake).
//   imem_req    - read request valid            (master -> slave)
//   imem_addr   - word-aligned read address     (master -> slave)
//   imem_gnt    - request accepted this cycle   (slave -> master)
//   imem_rvalid - read data valid, in order     (slave -> master)
//   imem_rdata  - read data                     (slave -> master)
// Modports: master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface pc_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Instruction buffer between the memory response path and decode. Stores
// {pc, instr} entries; the head entry is visible combinationally from the
// storage array, so a word pushed into an empty buffer shows up one cycle
// later (no write-to-read bypass).
// Parameters:
//   DEPTH     - number of entries, power of two, >= 2
// Ports:
//   clk       - clock
//   reset_n   - asynchronous active-low reset (control state only)
//   i_push    - write i_wdata at the tail
//   i_pop     - drop the head entry (ignored when empty)
//   i_flush   - discard all entries; wins over push and pop
//   i_wdata   - entry to write
//   o_rdata   - head entry
//   o_count   - number of valid entries
//   o_empty   - no valid entries
// -----------------------------------------------------------------------------
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  fetch_entry_t               i_wdata,
    output fetch_entry_t               o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    logic           w_push;
    logic           w_pop;

    // Overflow/underflow guards; the fetch credit check keeps pushes off a
    // full buffer, but a defensive guard costs nothing here.
    assign w_push = i_push && (r_count != FULL_CNT);
    assign w_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Storage is pure data: no reset, contents are qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Instruction fetch stage. Holds the PC, issues one word read at a time to
// instruction memory, buffers returned words with their PCs in fetch_fifo and
// hands them to decode over a valid/ready handshake. Execute-stage redirects
// flush the buffer and squash any in-flight wrong-path response.
//
// Optional build macro:
//   FETCH_STALL_CNT_EN - adds stall_cycles, a saturating count of cycles in
//                        which decode back-pressures a valid word or a memory
//                        request waits for grant.
//
// Parameters:
//   RESET_PC   - fetch address after reset (word aligned)
//   FIFO_DEPTH - instruction buffer entries (power of two, >= 2)
// Ports:
//   clk            - clock, all state on rising edge
//   reset_n        - asynchronous active-low reset
//   imem           - instruction memory channel (master modport)
//   redirect_valid - one-cycle pulse: change fetch PC
//   redirect_pc    - new PC, bits [1:0] ignored
//   out_valid      - instruction available to decode
//   out_ready      - decode accepts the head word
//   instruction    - head word (NOP when empty)
//   instr_pc       - PC of head word (RESET_PC when empty)
//   stall_cycles   - stall counter (FETCH_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pc_fetch_unit_if.master        imem,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            instruction,
    output logic [31:0]            instr_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_fetch_unit: FIFO_DEPTH must be a power of two >= 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("pc_fetch_unit: RESET_PC must be word aligned");
    end

    fetch_state_e        r_state;
    fetch_state_e        w_state_nxt;
    logic [31:0]         r_pc;
    logic [31:0]         r_req_pc;
    logic                r_run;

    logic                w_grant;
    logic                w_outstanding;
    logic                w_credit;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    fetch_entry_t        w_wdata;
    fetch_entry_t        w_head;

    // r_run keeps imem_req low while reset is asserted and for the first
    // cycle after release, so no request is ever driven out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Outstanding request exists in WAIT and DROP; only one may be in flight.
    assign w_outstanding = (r_state != ST_REQ);
    assign w_grant       = imem.imem_req && imem.imem_gnt;
    assign w_credit      = ({1'b0, w_count} + {{CNT_W{1'b0}}, w_outstanding})
                           < (CNT_W + 1)'(FIFO_DEPTH);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            // A response still owed by memory (granted now, or in flight and
            // not returning this cycle) must be swallowed in DROP.
            if (w_grant || (w_outstanding && !imem.imem_rvalid)) begin
                w_state_nxt = ST_DROP;
            end else begin
                w_state_nxt = ST_REQ;
            end
        end else begin
            case (r_state)
                ST_REQ:  if (w_grant)           w_state_nxt = ST_WAIT;
                ST_WAIT: if (imem.imem_rvalid)  w_state_nxt = ST_REQ;
                ST_DROP: if (imem.imem_rvalid)  w_state_nxt = ST_REQ;
                default:                        w_state_nxt = ST_REQ;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem.imem_req  = r_run && (r_state == ST_REQ) && w_credit;
        imem.imem_addr = r_pc;
        w_flush        = redirect_valid;
        w_push         = (r_state == ST_WAIT) && imem.imem_rvalid && !redirect_valid;
        w_pop          = out_valid && out_ready && !redirect_valid;
    end

    // PC register: redirect overrides the sequential increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= align_pc(redirect_pc);
        end else if (w_grant) begin
            r_pc <= r_pc + PC_INCR;
        end
    end

    // Address of the request in flight, paired with its returning data.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_req_pc <= r_pc;
        end
    end

    assign w_wdata.pc    = r_req_pc;
    assign w_wdata.instr = imem.imem_rdata;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign out_valid   = !w_empty;
    assign instruction = w_empty ? NOP_INSTR : w_head.instr;
    assign instr_pc    = w_empty ? RESET_PC  : w_head.pc;

`ifdef FETCH_STALL_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic        w_stall;
    logic [31:0] r_stall_cnt;

    assign w_stall = (out_valid && !out_ready) || (imem.imem_req && !imem.imem_gnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= sat_inc32(r_stall_cnt);
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

    // Response with nothing in flight: ignored by the FSM, but worth flagging.
    a_no_stray_rvalid: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(imem.imem_rvalid && (r_state == ST_REQ))
    ) else $warning("pc_fetch_unit: imem_rvalid with no outstanding request ignored");

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction fetch stage upstream of the decoder. Holds the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake. Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Accepts branch/jump redirects from execute and flushes wrong-path words.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.

Ports:
clk  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
imem_req  output  1  read request valid
imem_addr  output  32  word-aligned read address
imem_gnt  input  1  request accepted this cycle when imem_req && imem_gnt
imem_rvalid  input  1  read data valid, in order, at least 1 cycle after grant
imem_rdata  input  32  read data
redirect_valid  input  1  one-cycle pulse: change fetch PC
redirect_pc  input  32  new PC; bits [1:0] ignored, treated as 0
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts when out_valid && out_ready
instruction  output  32  FIFO head word, feeds decoder instruction input
instr_pc  output  32  PC of FIFO head word

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, FIFO empty, outstanding=0, state=REQ. imem_req=0, imem_addr=RESET_PC, out_valid=0, instruction=32'h0000_0013 (NOP), instr_pc=RESET_PC.
- Requests are issued from registered state. At most 1 outstanding request.
- States:
  - REQ: imem_req=1 when FIFO count + outstanding < FIFO_DEPTH, else 0. imem_addr=pc. On grant: outstanding=1, pc+=4, go WAIT.
  - WAIT: imem_req=0. On imem_rvalid: push {addr_of_request, imem_rdata}, outstanding=0, go REQ.
  - DROP: an outstanding wrong-path response is pending. imem_req=0. On imem_rvalid: discard the data, outstanding=0, go REQ.
- Throughput: one fetch per 2 cycles with single-cycle grant and 1-cycle response latency.
- PC arithmetic is 32-bit. 32'hFFFF_FFFC + 4 wraps to 0.
- Redirect takes priority over all same-cycle events:
  - FIFO flushed; out_valid=0 next cycle.
  - pc = {redirect_pc[31:2], 2'b00}.
  - If a request is outstanding, or is granted in the same cycle, go DROP. Otherwise go REQ.
  - A same-cycle rvalid in WAIT is discarded and the state goes REQ.
  - A redirect while in DROP updates pc and stays in DROP.
  - Simultaneous pop on the redirect cycle has no effect; the FIFO is flushed.
- FIFO:
  - Simultaneous push and pop when full is impossible, because issue is gated by the credit check.
  - Simultaneous push and pop when non-empty keeps the count unchanged.
  - Push into an empty FIFO appears at the output on the next cycle (no bypass).
- instruction and instr_pc hold their value while out_valid && !out_ready.
- imem_rvalid with no outstanding request is ignored. Flag it with an assertion in simulation.

Optional Feature:
FETCH_STALL_CNT_EN
- Defined: adds output port stall_cycles [31:0], reset to 0. It increments, saturating at 32'hFFFF_FFFF, on every cycle where out_valid && !out_ready, or imem_req && !imem_gnt.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package riscv_fetch_pkg holds:
  - the NOP constant 32'h0000_0013
  - the fetch state encoding (REQ, WAIT, DROP; 2 bits)
  - the default RESET_PC
  - the PC increment constant 4
- Sub-module fetch_fifo is natural: parameterised depth, 64-bit entry {pc, instr}, push, pop and flush inputs, count and empty outputs.
- FSM, PC register and credit logic stay in pc_fetch_unit.

Test Plan:
- Reset release, imem_gnt=1, rvalid 1 cycle after grant, rdata=addr^32'hA5A5_A5A5, out_ready=1 -> addresses 0,4,8,... issued; decode sees instr_pc 0,4,8 with matching data in order; nothing dropped or duplicated.
- out_ready=0 for 10 cycles -> exactly FIFO_DEPTH (2) words buffered; imem_req=0 after credits are exhausted; instruction/instr_pc stable; release -> words 0 and 4 are delivered first, then fetch resumes at 8.
- Redirect to 32'h0000_0103 while a request for 0x10 is outstanding -> state DROP, 0x10 data discarded, next imem_addr=32'h0000_0100, first delivered instr_pc=0x100.
- Redirect on the same cycle as rvalid in WAIT, and separately on the same cycle as a grant -> returned/granted word never reaches decode; fetch restarts at the redirect target.
- Redirect to 32'hFFFF_FFFC -> next fetch addresses 32'hFFFF_FFFC then 32'h0000_0000.
- reset_n asserted mid-WAIT, asynchronously between edges -> outputs return to reset values immediately; a stale rvalid after release is ignored; fetch restarts at RESET_PC. With FETCH_STALL_CNT_EN, 10 cycles of out_ready=0 with a full FIFO -> stall_cycles=10.
